// File: rtl/alarm_pkg.sv
// Shared types and default constants for the alarm buzzer driver.
// Holds the beeper state enum and the default cadence / duty-ramp settings.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        HOLD = 2'd3
    } beep_state_t;

    localparam int DEF_PWM_W       = 8;
    localparam int DEF_ON_PERIODS  = 100;
    localparam int DEF_OFF_PERIODS = 100;
    localparam int DEF_DUTY_START  = 32;
    localparam int DEF_DUTY_STEP   = 32;
    localparam int DEF_MAX_BURSTS  = 60;

endpackage

// File: rtl/pwm_carrier.sv
// PWM carrier: free-running PWM_W counter, wrap pulse and registered compare.
// Ports: clk, rst (async high), run (count enable), clr (sync counter clear),
//        duty (compare level), en_out (gate) -> wrap (comb), pwm (registered).
module pwm_carrier #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [PWM_W-1:0] duty,
    input  logic             en_out,
    output logic             wrap,
    output logic             pwm
);

    logic [PWM_W-1:0] cnt;

    // Last count of a carrier period while the counter is running.
    assign wrap = run && (cnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            pwm <= 1'b0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (run)
                cnt <= cnt + PWM_W'(1);
            // Strict less-than: duty 0 is always low, full-scale never hits 100%.
            pwm <= en_out && (cnt < duty);
        end
    end

endmodule

// File: rtl/alarm_pwm_beeper.sv
// Cadenced, duty-ramping PWM buzzer driver fed by the alarm clock level output.
// Ports: clk, rst (async high), alarm_in (level request), duty_max (ceiling)
//        -> pwm_out (buzzer), beeping (ON/OFF cadence), timed_out (HOLD).
module alarm_pwm_beeper
    import alarm_pkg::*;
#(
    parameter int PWM_W       = DEF_PWM_W,
    parameter int ON_PERIODS  = DEF_ON_PERIODS,
    parameter int OFF_PERIODS = DEF_OFF_PERIODS,
    parameter int DUTY_START  = DEF_DUTY_START,
    parameter int DUTY_STEP   = DEF_DUTY_STEP,
    parameter int MAX_BURSTS  = DEF_MAX_BURSTS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alarm_in,
    input  logic [PWM_W-1:0] duty_max,
    output logic             pwm_out,
    output logic             beeping,
    output logic             timed_out
);

    localparam int CNT_W = 16;
    localparam logic [PWM_W:0] START_X = (PWM_W+1)'(DUTY_START);
    localparam logic [PWM_W:0] STEP_X  = (PWM_W+1)'(DUTY_STEP);

    beep_state_t      state, state_n;
    logic [CNT_W-1:0] per_cnt, per_n;
    logic [CNT_W-1:0] burst_cnt, burst_n;
    logic [PWM_W-1:0] duty, duty_n;
    logic [PWM_W:0]   cap, step_sum;
    logic [PWM_W-1:0] duty_first, duty_next;
    logic             run, wrap;

    // One extra bit so the ramp saturates at the ceiling instead of wrapping.
    assign cap        = {1'b0, duty_max};
    assign step_sum   = {1'b0, duty} + STEP_X;
    assign duty_first = (START_X > cap) ? duty_max : START_X[PWM_W-1:0];
    assign duty_next  = (step_sum > cap) ? duty_max : step_sum[PWM_W-1:0];

    assign run = (state == ON) || (state == OFF);

    pwm_carrier #(.PWM_W(PWM_W)) u_carrier (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .clr    (!run),
        .duty   (duty),
        .en_out (state == ON),
        .wrap   (wrap),
        .pwm    (pwm_out)
    );

    always_comb begin
        state_n = state;
        per_n   = per_cnt;
        burst_n = burst_cnt;
        duty_n  = duty;
        unique case (state)
            IDLE: begin
                if (alarm_in) begin
                    state_n = ON;
                    per_n   = '0;
                    burst_n = '0;
                    duty_n  = duty_first;
                end
            end
            ON: begin
                if (!alarm_in) begin
                    state_n = IDLE;
                end else if (wrap) begin
                    if (per_cnt == CNT_W'(ON_PERIODS - 1)) begin
                        per_n = '0;
                        if (burst_cnt == CNT_W'(MAX_BURSTS - 1)) begin
                            state_n = HOLD;
                        end else begin
                            state_n = OFF;
                            burst_n = burst_cnt + CNT_W'(1);
                            duty_n  = duty_next;
                        end
                    end else begin
                        per_n = per_cnt + CNT_W'(1);
                    end
                end
            end
            OFF: begin
                if (!alarm_in) begin
                    state_n = IDLE;
                end else if (wrap) begin
                    if (per_cnt == CNT_W'(OFF_PERIODS - 1)) begin
                        state_n = ON;
                        per_n   = '0;
                    end else begin
                        per_n = per_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (!alarm_in)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            per_cnt   <= '0;
            burst_cnt <= '0;
            duty      <= '0;
            beeping   <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            state     <= state_n;
            per_cnt   <= per_n;
            burst_cnt <= burst_n;
            duty      <= duty_n;
            // beeping tracks the state one cycle behind, aligned with pwm_out.
            beeping   <= run;
            timed_out <= (state_n == HOLD);
        end
    end

endmodule
